// File: rtl/fifo_burst_reader_pkg.sv
// Shared controller definitions for the FIFO burst reader: FSM state
// encoding and the legal burst-length range.
package fifo_burst_reader_pkg;

    // FSM state encoding (kept as plain constants so older code can reuse it)
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_FILL = 2'd1;
    localparam logic [1:0] ST_STREAM    = 2'd2;

    // Largest burst the reader will accept
    localparam int MAX_BURST_LEN = 16;

    // A burst length is usable when it is non-zero and within the maximum
    function automatic logic burst_len_legal(input int unsigned len);
        return (len != 0) && (len <= MAX_BURST_LEN);
    endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Reads one burst of burst_len words out of a show-ahead FIFO and presents
// them on a registered valid/ready output.
//
// Handshake: a word transfers on out_data in every cycle where
// out_valid && out_ready are both high at the rising edge. Once out_valid
// is raised, out_valid/out_data/out_last stay unchanged until that
// transfer happens; out_valid never depends combinationally on out_ready.
//
// The reader waits until the FIFO already holds the whole burst before it
// pops anything, so the burst leaves the block without bubbles whenever
// the consumer keeps out_ready high. dbg_state exposes the FSM state.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH_P2 = 6,
    parameter int LEN_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic                abort,
    input  logic [WIDTH-1:0]    fifo_data,
    input  logic                fifo_empty,
    input  logic [DEPTH_P2:0]   fifo_fillcount,
    output logic                fifo_get,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    // Common width for comparing the fill level against the words still owed
    localparam int CMP_W = (DEPTH_P2 + 1 > LEN_W) ? (DEPTH_P2 + 1) : LEN_W;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             done_q, done_d;

    logic accept;
    logic pop;
    logic fill_ok;
    logic start_ok;

    assign accept   = out_valid_q && out_ready;
    assign fill_ok  = CMP_W'(fifo_fillcount) >= CMP_W'(remaining_q);
    assign start_ok = start && burst_len_legal(32'(burst_len));

    // Pop only while streaming, with words still owed, data present, room in
    // the output register, and no abort or reset this cycle.
    assign pop = !reset
              && (state_q == ST_STREAM)
              && (remaining_q != '0)
              && !fifo_empty
              && (!out_valid_q || out_ready)
              && !abort;

    // Next-state logic for the FSM, burst counter and output register
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    remaining_d = burst_len;
                    state_d     = ST_WAIT_FILL;
                end
            end

            ST_WAIT_FILL: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end else if (fill_ok) begin
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (abort) begin
                    // Words already popped are dropped along with the burst
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    if (pop) begin
                        out_data_d  = fifo_data;
                        out_valid_d = 1'b1;
                        out_last_d  = (remaining_q == LEN_W'(1));
                        remaining_d = remaining_q - LEN_W'(1);
                    end else if (accept) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                    // The final word cannot coincide with a pop: nothing is owed
                    if (accept && out_last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign fifo_get  = pop;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based show-ahead FIFO model feeds the
// design, every cycle is recorded, and each scenario task checks its trace.
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;

  localparam int WIDTH    = 8;
  localparam int DEPTH_P2 = 6;
  localparam int LEN_W    = 5;
  localparam int FW       = DEPTH_P2 + 1;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             abort;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_fillcount;
  logic             fifo_get;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  fifo_burst_reader #(.WIDTH(WIDTH), .DEPTH_P2(DEPTH_P2), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .burst_len      (burst_len),
    .abort          (abort),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_fillcount (fifo_fillcount),
    .fifo_get       (fifo_get),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- upstream FIFO model ----------------
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] push_q[$];
  int flush_req = 0;
  int flush_seen = 0;

  // Pops on fifo_get seen at the edge, then applies queued pushes, 1ns later
  initial begin : fifo_model
    logic pop_now;
    fifo_data = '0;
    fifo_empty = 1'b1;
    fifo_fillcount = '0;
    forever begin
      @(posedge clk);
      pop_now = fifo_get;
      #1;
      if (flush_req != flush_seen) begin
        fifo_q.delete();
        flush_seen = flush_req;
      end else if (pop_now === 1'b1 && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
      end
      while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
      fifo_empty = (fifo_q.size() == 0);
      fifo_fillcount = FW'(fifo_q.size());
      fifo_data = fifo_empty ? '0 : fifo_q[0];
    end
  end

  // ---------------- per-cycle observation ----------------
  typedef struct {
    logic             get;
    logic             valid;
    logic             last;
    logic             done;
    logic             busy;
    logic             acc;
    logic             empty;
    logic [1:0]       state;
    logic [WIDTH-1:0] data;
    logic [FW-1:0]    fill;
  } obs_t;

  obs_t trace_q[$];
  obs_t cur;
  logic [WIDTH-1:0] exp_q[$];

  // Samples the current cycle at the falling edge, then moves to the next
  // cycle's drive point (2ns after the rising edge).
  task automatic clock_cycle();
    @(negedge clk);
    cur.get   = fifo_get;
    cur.valid = out_valid;
    cur.last  = out_last;
    cur.done  = done;
    cur.busy  = busy;
    cur.acc   = out_valid && out_ready;
    cur.empty = fifo_empty;
    cur.state = dbg_state;
    cur.data  = out_data;
    cur.fill  = fifo_fillcount;
    trace_q.push_back(cur);
    @(posedge clk);
    #2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [WIDTH-1:0] v);
    push_q.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    burst_len = '0;
    flush_req++;
    clock_cycle();
    clock_cycle();
    reset = 1'b0;
    trace_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t t;
    reset = 1'b1;
    start = 1'b1;
    burst_len = LEN_W'(3);
    abort = 1'b0;
    out_ready = 1'b1;
    push_word(8'hC1);
    push_word(8'hC2);
    @(posedge clk);
    #2;
    trace_q.delete();
    repeat (3) clock_cycle();
    reset = 1'b0;
    start = 1'b0;
    clock_cycle();
    for (int i = 0; i < 4; i++) begin
      t = trace_q[i];
      vectors++; if (t.get !== 1'b0) begin miscompares++; $display("FAIL reset_get[%0d]: got %b want 0", i, t.get); end
      vectors++; if (t.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid[%0d]: got %b want 0", i, t.valid); end
      vectors++; if (t.last !== 1'b0) begin miscompares++; $display("FAIL reset_last[%0d]: got %b want 0", i, t.last); end
      vectors++; if (t.data !== '0) begin miscompares++; $display("FAIL reset_data[%0d]: got %h want 00", i, t.data); end
      vectors++; if (t.done !== 1'b0) begin miscompares++; $display("FAIL reset_done[%0d]: got %b want 0", i, t.done); end
      vectors++; if (t.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b want 0", i, t.busy); end
    end
  endtask

  task automatic test_basic_burst();
    obs_t t;
    logic exp_get, exp_valid, exp_last, exp_done, exp_busy;
    logic [WIDTH-1:0] exp_data;
    do_reset();
    for (int k = 0; k < 4; k++) push_word(WIDTH'(8'h11 + k));
    clock_cycle();
    trace_q.delete();
    start = 1'b1;
    burst_len = LEN_W'(4);
    clock_cycle();
    start = 1'b0;
    repeat (9) clock_cycle();
    for (int i = 0; i < 10; i++) begin
      t = trace_q[i];
      exp_get   = (i >= 2 && i <= 5);
      exp_valid = (i >= 3 && i <= 6);
      exp_last  = (i == 6);
      exp_done  = (i == 7);
      exp_busy  = (i >= 1 && i <= 6);
      vectors++; if (t.get !== exp_get) begin miscompares++; $display("FAIL basic_get[%0d]: got %b want %b", i, t.get, exp_get); end
      vectors++; if (t.valid !== exp_valid) begin miscompares++; $display("FAIL basic_valid[%0d]: got %b want %b", i, t.valid, exp_valid); end
      vectors++; if (t.last !== exp_last) begin miscompares++; $display("FAIL basic_last[%0d]: got %b want %b", i, t.last, exp_last); end
      vectors++; if (t.done !== exp_done) begin miscompares++; $display("FAIL basic_done[%0d]: got %b want %b", i, t.done, exp_done); end
      vectors++; if (t.busy !== exp_busy) begin miscompares++; $display("FAIL basic_busy[%0d]: got %b want %b", i, t.busy, exp_busy); end
      if (exp_valid) begin
        exp_data = WIDTH'(8'h11 + (i - 3));
        vectors++; if (t.data !== exp_data) begin miscompares++; $display("FAIL basic_data[%0d]: got %h want %h", i, t.data, exp_data); end
      end
    end
    t = trace_q[1];
    vectors++; if (t.state !== ST_WAIT_FILL) begin miscompares++; $display("FAIL basic_state1: got %0d want %0d", t.state, ST_WAIT_FILL); end
    t = trace_q[2];
    vectors++; if (t.state !== ST_STREAM) begin miscompares++; $display("FAIL basic_state2: got %0d want %0d", t.state, ST_STREAM); end
    t = trace_q[9];
    vectors++; if (t.fill !== FW'(0)) begin miscompares++; $display("FAIL basic_fill_end: got %0d want 0", t.fill); end
  endtask

  task automatic test_wait_fill();
    obs_t t;
    logic exp_get, exp_valid, exp_last, exp_done;
    logic [WIDTH-1:0] exp_data;
    do_reset();
    push_word(8'hA0);
    push_word(8'hA1);
    clock_cycle();
    trace_q.delete();
    start = 1'b1;
    burst_len = LEN_W'(4);
    clock_cycle();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 10) begin
        push_word(8'hA2);
        push_word(8'hA3);
      end
      clock_cycle();
    end
    // Fill reaches 4 in cycle 11, so streaming starts in cycle 12
    for (int i = 0; i <= 20; i++) begin
      t = trace_q[i];
      exp_get   = (i >= 12 && i <= 15);
      exp_valid = (i >= 13 && i <= 16);
      exp_last  = (i == 16);
      exp_done  = (i == 17);
      vectors++; if (t.get !== exp_get) begin miscompares++; $display("FAIL wait_get[%0d]: got %b want %b", i, t.get, exp_get); end
      vectors++; if (t.valid !== exp_valid) begin miscompares++; $display("FAIL wait_valid[%0d]: got %b want %b", i, t.valid, exp_valid); end
      vectors++; if (t.last !== exp_last) begin miscompares++; $display("FAIL wait_last[%0d]: got %b want %b", i, t.last, exp_last); end
      vectors++; if (t.done !== exp_done) begin miscompares++; $display("FAIL wait_done[%0d]: got %b want %b", i, t.done, exp_done); end
      if (exp_valid) begin
        exp_data = WIDTH'(8'hA0 + (i - 13));
        vectors++; if (t.data !== exp_data) begin miscompares++; $display("FAIL wait_data[%0d]: got %h want %h", i, t.data, exp_data); end
      end
    end
    t = trace_q[5];
    vectors++; if (t.busy !== 1'b1) begin miscompares++; $display("FAIL wait_busy: got %b want 1", t.busy); end
  endtask

  task automatic test_backpressure();
    obs_t t, n;
    int accepted;
    int dones;
    logic [WIDTH-1:0] words[3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      words[k] = WIDTH'($urandom_range(0, 255));
      push_word(words[k]);
    end
    clock_cycle();
    trace_q.delete();
    start = 1'b1;
    burst_len = LEN_W'(3);
    out_ready = 1'b1;
    clock_cycle();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      clock_cycle();
    end
    out_ready = 1'b1;
    accepted = 0;
    dones = 0;
    for (int i = 0; i < trace_q.size(); i++) begin
      t = trace_q[i];
      if (t.valid && !t.acc) begin
        vectors++; if (t.get !== 1'b0) begin miscompares++; $display("FAIL bp_get_stalled[%0d]: got %b want 0", i, t.get); end
        if (i + 1 < trace_q.size()) begin
          n = trace_q[i + 1];
          vectors++; if (n.valid !== 1'b1 || n.data !== t.data || n.last !== t.last) begin
            miscompares++; $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", i + 1, n.valid, n.data, n.last, t.data, t.last);
          end
        end
      end
      if (t.acc) begin
        if (accepted < 3) begin
          vectors++; if (t.data !== words[accepted]) begin miscompares++; $display("FAIL bp_word%0d: got %h want %h", accepted, t.data, words[accepted]); end
          vectors++; if (t.last !== (accepted == 2)) begin miscompares++; $display("FAIL bp_last%0d: got %b want %b", accepted, t.last, accepted == 2); end
        end
        accepted++;
      end
      if (t.done) dones++;
    end
    vectors++; if (accepted != 3) begin miscompares++; $display("FAIL bp_count: got %0d want 3", accepted); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL bp_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_abort();
    obs_t t;
    int gets;
    do_reset();
    for (int k = 0; k < 4; k++) push_word(WIDTH'(8'h31 + k));
    clock_cycle();
    trace_q.delete();
    start = 1'b1;
    burst_len = LEN_W'(4);
    clock_cycle();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      abort = (c == 3);
      clock_cycle();
    end
    abort = 1'b0;
    t = trace_q[2];
    vectors++; if (t.get !== 1'b1) begin miscompares++; $display("FAIL abort_first_pop: got %b want 1", t.get); end
    t = trace_q[3];
    vectors++; if (t.get !== 1'b0) begin miscompares++; $display("FAIL abort_no_pop: got %b want 0", t.get); end
    t = trace_q[4];
    vectors++; if (t.busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy=%b want 0", t.busy); end
    vectors++; if (t.valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b want 0", t.valid); end
    vectors++; if (t.last !== 1'b0) begin miscompares++; $display("FAIL abort_last: got %b want 0", t.last); end
    vectors++; if (t.fill !== FW'(3)) begin miscompares++; $display("FAIL abort_fill: got %0d want 3", t.fill); end
    gets = 0;
    for (int i = 0; i < trace_q.size(); i++) begin
      t = trace_q[i];
      if (t.get) gets++;
      vectors++; if (t.done !== 1'b0) begin miscompares++; $display("FAIL abort_done[%0d]: got %b want 0", i, t.done); end
    end
    vectors++; if (gets != 1) begin miscompares++; $display("FAIL abort_pop_count: got %0d want 1", gets); end
    t = trace_q[8];
    vectors++; if (t.fill !== FW'(3)) begin miscompares++; $display("FAIL abort_fill_end: got %0d want 3", t.fill); end
  endtask

  task automatic test_reset_midburst();
    obs_t t;
    int accepted;
    int dones;
    do_reset();
    for (int k = 0; k < 8; k++) push_word(WIDTH'(8'h40 + k));
    clock_cycle();
    trace_q.delete();
    start = 1'b1;
    burst_len = LEN_W'(8);
    clock_cycle();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      reset = (c == 4);
      clock_cycle();
    end
    reset = 1'b0;
    t = trace_q[3];
    vectors++; if (t.get !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pop_before: got %b want 1", t.get); end
    t = trace_q[4];
    vectors++; if (t.get !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_pop: got %b want 0", t.get); end
    t = trace_q[5];
    vectors++; if (t.valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", t.valid); end
    vectors++; if (t.last !== 1'b0) begin miscompares++; $display("FAIL rst_mid_last: got %b want 0", t.last); end
    vectors++; if (t.data !== '0) begin miscompares++; $display("FAIL rst_mid_data: got %h want 00", t.data); end
    vectors++; if (t.done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done: got %b want 0", t.done); end
    vectors++; if (t.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", t.busy); end
    vectors++; if (t.fill !== FW'(6)) begin miscompares++; $display("FAIL rst_mid_fill: got %0d want 6", t.fill); end
    trace_q.delete();
    start = 1'b1;
    burst_len = LEN_W'(1);
    clock_cycle();
    start = 1'b0;
    repeat (6) clock_cycle();
    accepted = 0;
    dones = 0;
    for (int i = 0; i < trace_q.size(); i++) begin
      t = trace_q[i];
      if (t.acc) begin
        accepted++;
        vectors++; if (t.data !== 8'h42 || t.last !== 1'b1) begin miscompares++; $display("FAIL rst_single_word: got d=%h l=%b want d=42 l=1", t.data, t.last); end
      end
      if (t.done) dones++;
    end
    vectors++; if (accepted != 1) begin miscompares++; $display("FAIL rst_single_count: got %0d want 1", accepted); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL rst_single_done: got %0d want 1", dones); end
  endtask

  task automatic test_ignored_starts();
    obs_t t;
    int accepted;
    int dones;
    do_reset();
    push_word(8'h50);
    push_word(8'h51);
    clock_cycle();
    trace_q.delete();
    start = 1'b1;
    burst_len = '0;
    clock_cycle();
    start = 1'b0;
    repeat (3) clock_cycle();
    for (int i = 1; i < trace_q.size(); i++) begin
      t = trace_q[i];
      vectors++; if (t.busy !== 1'b0 || t.get !== 1'b0) begin miscompares++; $display("FAIL len0_ignored[%0d]: got busy=%b get=%b want 0 0", i, t.busy, t.get); end
    end
    trace_q.delete();
    start = 1'b1;
    burst_len = LEN_W'(4);
    clock_cycle();
    start = 1'b0;
    repeat (2) clock_cycle();
    start = 1'b1;
    burst_len = LEN_W'(1);
    clock_cycle();
    start = 1'b0;
    repeat (3) clock_cycle();
    for (int i = 1; i < trace_q.size(); i++) begin
      t = trace_q[i];
      vectors++; if (t.busy !== 1'b1 || t.get !== 1'b0) begin miscompares++; $display("FAIL busy_start_ignored[%0d]: got busy=%b get=%b want 1 0", i, t.busy, t.get); end
    end
    trace_q.delete();
    push_word(8'h52);
    push_word(8'h53);
    repeat (15) clock_cycle();
    accepted = 0;
    dones = 0;
    for (int i = 0; i < trace_q.size(); i++) begin
      t = trace_q[i];
      if (t.acc) begin
        vectors++; if (t.data !== WIDTH'(8'h50 + accepted) || t.last !== (accepted == 3)) begin
          miscompares++; $display("FAIL busy_burst_word%0d: got d=%h l=%b want d=%h l=%b", accepted, t.data, t.last, WIDTH'(8'h50 + accepted), accepted == 3);
        end
        accepted++;
      end
      if (t.done) dones++;
    end
    vectors++; if (accepted != 4) begin miscompares++; $display("FAIL busy_burst_count: got %0d want 4", accepted); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL busy_burst_done: got %0d want 1", dones); end
  endtask

  // Random bursts against a word-stream scoreboard: every burst of length L
  // must deliver the next L words pushed, in order, last flag on the final one.
  task automatic test_random_bursts();
    int len, pre, got, pushed_total, consumed, extra;
    logic seen_done;
    logic [WIDTH-1:0] w, exp_w;
    do_reset();
    exp_q.delete();
    pushed_total = 0;
    consumed = 0;
    for (int b = 0; b < 30; b++) begin
      len = $urandom_range(1, 16);
      extra = (fifo_fillcount < FW'(40)) ? $urandom_range(0, 2) : 0;
      pre = $urandom_range(0, len);
      for (int k = 0; k < pre; k++) begin
        if (pushed_total < consumed + len + extra) begin
          w = WIDTH'($urandom_range(0, 255));
          push_word(w);
          exp_q.push_back(w);
          pushed_total++;
        end
      end
      got = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 300 && !seen_done; c++) begin
        start = (c == 0);
        burst_len = LEN_W'(len);
        out_ready = ($urandom_range(0, 3) != 0);
        if (c != 0 && pushed_total < consumed + len + extra && $urandom_range(0, 2) == 0) begin
          w = WIDTH'($urandom_range(0, 255));
          push_word(w);
          exp_q.push_back(w);
          pushed_total++;
        end
        clock_cycle();
        vectors++; if (cur.get && cur.empty) begin miscompares++; $display("FAIL rnd_get_empty b%0d c%0d: got get=1 with empty=1", b, c); end
        if (cur.acc) begin
          exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          vectors++; if (cur.data !== exp_w) begin miscompares++; $display("FAIL rnd_data b%0d w%0d: got %h want %h", b, got, cur.data, exp_w); end
          vectors++; if (cur.last !== (got == len - 1)) begin miscompares++; $display("FAIL rnd_last b%0d w%0d: got %b want %b", b, got, cur.last, got == len - 1); end
          got++;
        end
        if (cur.done) begin
          seen_done = 1'b1;
          vectors++; if (got != len) begin miscompares++; $display("FAIL rnd_done_early b%0d: got %0d words want %0d", b, got, len); end
        end
      end
      start = 1'b0;
      out_ready = 1'b1;
      consumed += len;
      vectors++; if (!seen_done) begin miscompares++; $display("FAIL rnd_timeout b%0d: got no done want done within 300 cycles", b); end
    end
  endtask

  // ---------------- sequencing and report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    burst_len = '0;
    abort = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic_burst();
    test_wait_fill();
    test_backpressure();
    test_abort();
    test_reset_midburst();
    test_ignored_starts();
    test_random_bursts();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want finished by 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
